// File: rtl/msg_packer_pkg.sv
// Shared constants and types for the hash_engine message packer.
// Purpose : block/word geometry defaults and the accumulator state type.
// Ports   : none (package).
package msg_packer_pkg;

  localparam int BLOCK_DATA_WIDTH = 512;
  localparam int HOST_WORD_WIDTH  = 32;
  localparam int SIDEBAND_WIDTH   = 128;
  localparam int WORDS_PER_BEAT   = BLOCK_DATA_WIDTH / HOST_WORD_WIDTH;
  localparam int WORD_IDX_WIDTH   = $clog2(WORDS_PER_BEAT);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } acc_state_e;

endpackage

// File: rtl/msg_packer_lane_wr.sv
// Lane decode for the packer accumulator.
// Purpose : places one host word (and its byte enables) into the lane of a
//           full-width beat selected by idx; lane 0 is the most significant.
// Ports   : idx (lane index), word_data/word_keep (host word),
//           data_wr/data_mask, keep_wr/keep_mask (positioned word and lane masks).
// Config  : `PACKER_BYTE_SWAP_EN reverses the bytes of each word and the bits
//           of its tkeep before placement (little-endian hosts).
module msg_packer_lane_wr
  import msg_packer_pkg::*;
#(
  parameter int S_W   = HOST_WORD_WIDTH,
  parameter int M_W   = BLOCK_DATA_WIDTH,
  parameter int IDX_W = WORD_IDX_WIDTH
) (
  input  logic [IDX_W-1:0] idx,
  input  logic [S_W-1:0]   word_data,
  input  logic [S_W/8-1:0] word_keep,
  output logic [M_W-1:0]   data_wr,
  output logic [M_W-1:0]   data_mask,
  output logic [M_W/8-1:0] keep_wr,
  output logic [M_W/8-1:0] keep_mask
);

  localparam int N   = M_W / S_W;
  localparam int S_K = S_W / 8;
  localparam int M_K = M_W / 8;

  logic [S_W-1:0] lane_data;
  logic [S_K-1:0] lane_keep;
  int             lane_shift;

  always_comb begin
    lane_data = word_data;
    lane_keep = word_keep;
`ifdef PACKER_BYTE_SWAP_EN
    for (int b = 0; b < S_K; b++) begin
      lane_data[8*b +: 8] = word_data[S_W-8-8*b +: 8];
      lane_keep[b]        = word_keep[S_K-1-b];
    end
`endif
    // lane 0 sits at the top of the beat, so shift down from the MSB end
    lane_shift = N - 1 - int'(idx);
    data_wr    = {{(M_W-S_W){1'b0}}, lane_data} << (lane_shift * S_W);
    data_mask  = {{(M_W-S_W){1'b0}}, {S_W{1'b1}}} << (lane_shift * S_W);
    keep_wr    = {{(M_K-S_K){1'b0}}, lane_keep} << (lane_shift * S_K);
    keep_mask  = {{(M_K-S_K){1'b0}}, {S_K{1'b1}}} << (lane_shift * S_K);
  end

endmodule

// File: rtl/msg_packer.sv
// Message packer: 32b host AXIS word stream -> 512b AXIS beats for hash_engine.
// Purpose : accumulates N words per beat in ACC, hands complete beats to an
//           output register OUT that drives m_axis_*. One word per cycle.
// Ports   : axi_aclk, axi_reset (async, active high);
//           s_axis_* word input (tdata/tkeep/tuser/tvalid/tready/tlast);
//           m_axis_* beat output (tdata/tkeep/tuser/tvalid/tready/tlast).
// Config  : `PACKER_BYTE_SWAP_EN (see msg_packer_lane_wr).
//
// state   | meaning
// ST_FILL | ACC collecting words, index = next lane
// ST_FULL | ACC complete; moves to OUT when OUT is empty or draining,
//         | otherwise held (PEND) with s_axis_tready low
module msg_packer
  import msg_packer_pkg::*;
#(
  parameter int S_AXIS_DATA_WIDTH  = HOST_WORD_WIDTH,
  parameter int M_AXIS_DATA_WIDTH  = BLOCK_DATA_WIDTH,
  parameter int S_AXIS_TUSER_WIDTH = SIDEBAND_WIDTH,
  parameter int M_AXIS_TUSER_WIDTH = SIDEBAND_WIDTH
) (
  input  logic                            axi_aclk,
  input  logic                            axi_reset,
  input  logic [S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast
);

  localparam int N     = M_AXIS_DATA_WIDTH / S_AXIS_DATA_WIDTH;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int M_K   = M_AXIS_DATA_WIDTH / 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  acc_state_e                     state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic                           first_q, first_d;
  logic [M_AXIS_DATA_WIDTH-1:0]   acc_data_q, acc_data_d;
  logic [M_K-1:0]                 acc_keep_q, acc_keep_d;
  logic [S_AXIS_TUSER_WIDTH-1:0]  acc_user_q, acc_user_d;
  logic                           acc_last_q, acc_last_d;
  logic                           out_valid_q, out_valid_d;
  logic [M_AXIS_DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [M_K-1:0]                 out_keep_q, out_keep_d;
  logic [M_AXIS_TUSER_WIDTH-1:0]  out_user_q, out_user_d;
  logic                           out_last_q, out_last_d;

  logic [M_AXIS_DATA_WIDTH-1:0]   data_wr, data_mask;
  logic [M_K-1:0]                 keep_wr, keep_mask;
  logic                           out_free, transfer, accept, complete;

  msg_packer_lane_wr #(
    .S_W   (S_AXIS_DATA_WIDTH),
    .M_W   (M_AXIS_DATA_WIDTH),
    .IDX_W (IDX_W)
  ) u_lane_wr (
    .idx       (idx_q),
    .word_data (s_axis_tdata),
    .word_keep (s_axis_tkeep),
    .data_wr   (data_wr),
    .data_mask (data_mask),
    .keep_wr   (keep_wr),
    .keep_mask (keep_mask)
  );

  // OUT can take a beat this edge if it is empty or its beat is leaving now
  assign out_free      = !out_valid_q || m_axis_tready;
  assign transfer      = (state_q == ST_FULL) && out_free;
  assign s_axis_tready = !((state_q == ST_FULL) && !out_free);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign complete      = accept && (s_axis_tlast || (idx_q == LAST_IDX));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    first_d     = first_q;
    acc_data_d  = acc_data_q;
    acc_keep_d  = acc_keep_q;
    acc_user_d  = acc_user_q;
    acc_last_d  = acc_last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_user_d  = out_user_q;
    out_last_d  = out_last_q;

    if (transfer) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_data_q;
      out_keep_d  = acc_keep_q;
      out_user_d  = acc_user_q;
      out_last_d  = acc_last_q;
      // cleared so lanes left unwritten by a short tlast beat read as zero
      acc_data_d  = '0;
      acc_keep_d  = '0;
      acc_last_d  = 1'b0;
      state_d     = ST_FILL;
    end else if (m_axis_tready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      acc_data_d = (acc_data_d & ~data_mask) | data_wr;
      acc_keep_d = (acc_keep_d & ~keep_mask) | keep_wr;
      if (first_q) begin
        acc_user_d = s_axis_tuser;
      end
      first_d = s_axis_tlast;
      if (complete) begin
        idx_d      = '0;
        acc_last_d = s_axis_tlast;
        state_d    = ST_FULL;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      state_q     <= ST_FILL;
      idx_q       <= '0;
      first_q     <= 1'b1;
      acc_data_q  <= '0;
      acc_keep_q  <= '0;
      acc_user_q  <= '0;
      acc_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_user_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      first_q     <= first_d;
      acc_data_q  <= acc_data_d;
      acc_keep_q  <= acc_keep_d;
      acc_user_q  <= acc_user_d;
      acc_last_q  <= acc_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_user_q  <= out_user_d;
      out_last_q  <= out_last_d;
    end
  end

  assign m_axis_tdata  = out_data_q;
  assign m_axis_tkeep  = out_keep_q;
  assign m_axis_tuser  = out_user_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tlast  = out_last_q;

endmodule
